// File: rtl/temporal_encoder_pkg.sv
// Shared definitions for the temporal encoder: default sizes, FSM state
// encodings and a constant log2 helper.
package temporal_encoder_pkg;

  localparam int TE_HV_DIMENSION = 1024;
  localparam int TE_NGRAM_SIZE   = 3;
  localparam int TE_WINDOW       = 5;

  typedef enum logic [1:0] {
    TE_FILL          = 2'd0,
    TE_ACCUM         = 2'd1,
    TE_OUTPUT_STABLE = 2'd2
  } te_state_e;

  function automatic int ceil_log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/temporal_encoder_hv_bundler.sv
// hv_bundler: one saturation-free counter per hypervector bit; the majority
// output already includes the n-gram presented this cycle.
module hv_bundler
  import temporal_encoder_pkg::*;
#(
  parameter int HV_DIMENSION = TE_HV_DIMENSION,
  parameter int WINDOW       = TE_WINDOW,
  parameter int CNT_WIDTH    = ceil_log2(TE_WINDOW + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    add_i,
  input  logic                    clear_i,
  input  logic [0:HV_DIMENSION-1] ngram_i,
  output logic [0:HV_DIMENSION-1] majority_o
);

  localparam logic [CNT_WIDTH:0] HALF = (CNT_WIDTH + 1)'(WINDOW / 2);

  for (genvar gi = 0; gi < HV_DIMENSION; gi++) begin : g_bit
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH:0]   sum_d;

    assign sum_d          = (CNT_WIDTH + 1)'(cnt_q) + (CNT_WIDTH + 1)'(ngram_i[gi]);
    // Strict comparison makes an even-window tie resolve to 0.
    assign majority_o[gi] = (sum_d > HALF);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (clear_i) begin
        cnt_q <= '0;
      end else if (add_i) begin
        cnt_q <= cnt_q + CNT_WIDTH'(ngram_i[gi]);
      end
    end
  end

endmodule

// File: rtl/temporal_encoder.sv
// Temporal encoder: permute-and-XOR n-gram binding over a sliding history,
// majority bundling of WINDOW n-grams. TEMPORAL_ENCODER_WINDOW_CNT_EN adds WindowCnt_DO.
module temporal_encoder
  import temporal_encoder_pkg::*;
#(
  parameter int HV_DIMENSION = TE_HV_DIMENSION,
  parameter int NGRAM_SIZE   = TE_NGRAM_SIZE,
  parameter int WINDOW       = TE_WINDOW
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RBI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [0:HV_DIMENSION-1] HypervectorOut_DO
`ifdef TEMPORAL_ENCODER_WINDOW_CNT_EN
  ,
  output logic [15:0]             WindowCnt_DO
`endif
);

  localparam int        CNT_WIDTH   = ceil_log2(WINDOW + 1);
  localparam int        FILL_W      = (NGRAM_SIZE > 1) ? ceil_log2(NGRAM_SIZE) : 1;
  localparam te_state_e RESET_STATE = (NGRAM_SIZE == 1) ? TE_ACCUM : TE_FILL;

  te_state_e                 state_q;
  logic [FILL_W-1:0]         fill_q;
  logic [CNT_WIDTH-1:0]      win_q;
  logic                      ready_q;
  logic                      valid_q;
  logic [0:HV_DIMENSION-1]   hv_out_q;

  logic                      accept_d;
  logic                      last_d;
  logic                      add_d;
  logic                      clear_d;
  logic [0:HV_DIMENSION-1]   ngram_d;
  logic [0:HV_DIMENSION-1]   majority_d;

  function automatic logic [0:HV_DIMENSION-1] rho_k(input logic [0:HV_DIMENSION-1] x,
                                                     input int k);
    logic [0:HV_DIMENSION-1] r;
    for (int i = 0; i < HV_DIMENSION; i++) begin
      r[i] = x[(i + HV_DIMENSION - (k % HV_DIMENSION)) % HV_DIMENSION];
    end
    return r;
  endfunction

  assign accept_d = ValidIn_SI & ready_q;
  assign last_d   = (win_q == CNT_WIDTH'(WINDOW - 1));
  assign add_d    = accept_d && (state_q == TE_ACCUM) && !last_d;
  assign clear_d  = accept_d && (state_q == TE_ACCUM) && last_d;

  if (NGRAM_SIZE > 1) begin : g_hist
    // hist_q[k] holds the sample accepted k samples before the current one.
    logic [0:HV_DIMENSION-1] hist_q [1:NGRAM_SIZE-1];

    for (genvar gi = 1; gi < NGRAM_SIZE; gi++) begin : g_stage
      logic [0:HV_DIMENSION-1] src_d;
      if (gi == 1) begin : g_head
        assign src_d = HypervectorIn_DI;
      end else begin : g_tail
        assign src_d = hist_q[gi-1];
      end

      always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
          hist_q[gi] <= '0;
        end else if (accept_d) begin
          hist_q[gi] <= src_d;
        end
      end
    end

    always_comb begin
      ngram_d = HypervectorIn_DI;
      for (int k = 1; k < NGRAM_SIZE; k++) begin
        ngram_d = ngram_d ^ rho_k(hist_q[k], k);
      end
    end
  end else begin : g_no_hist
    assign ngram_d = HypervectorIn_DI;
  end

  hv_bundler #(
    .HV_DIMENSION (HV_DIMENSION),
    .WINDOW       (WINDOW),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_bundler (
    .clk_i      (Clk_CI),
    .rst_ni     (Reset_RBI),
    .add_i      (add_d),
    .clear_i    (clear_d),
    .ngram_i    (ngram_d),
    .majority_o (majority_d)
  );

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      state_q  <= RESET_STATE;
      fill_q   <= '0;
      win_q    <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      hv_out_q <= '0;
    end else begin
      case (state_q)
        TE_FILL: begin
          ready_q <= 1'b1;
          if (accept_d) begin
            fill_q <= fill_q + 1'b1;
            if (fill_q == FILL_W'(NGRAM_SIZE - 2)) begin
              state_q <= TE_ACCUM;
            end
          end
        end
        TE_ACCUM: begin
          ready_q <= 1'b1;
          if (accept_d) begin
            if (last_d) begin
              win_q    <= '0;
              hv_out_q <= majority_d;
              valid_q  <= 1'b1;
              ready_q  <= 1'b0;
              state_q  <= TE_OUTPUT_STABLE;
            end else begin
              win_q <= win_q + 1'b1;
            end
          end
        end
        TE_OUTPUT_STABLE: begin
          if (ReadyIn_SI) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= TE_ACCUM;
          end
        end
        default: begin
          state_q <= RESET_STATE;
        end
      endcase
    end
  end

  assign ReadyOut_SO       = ready_q;
  assign ValidOut_SO       = valid_q;
  assign HypervectorOut_DO = hv_out_q;

`ifdef TEMPORAL_ENCODER_WINDOW_CNT_EN
  logic [15:0] win_cnt_q;

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      win_cnt_q <= '0;
    end else if (valid_q && ReadyIn_SI && (win_cnt_q != 16'hFFFF)) begin
      win_cnt_q <= win_cnt_q + 16'd1;
    end
  end

  assign WindowCnt_DO = win_cnt_q;
`endif

endmodule

// File: tb/tb_temporal_encoder.sv
// Bench for temporal_encoder: instance 0 uses WINDOW=3, instance 1 WINDOW=2,
// both D=8 and NGRAM_SIZE=3, checked every cycle against a bit-counting model.
module tb_temporal_encoder;

  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         valid_in [2];
  logic         ready_in [2];
  logic [0:D-1] hv_in    [2];
  logic         rdy      [2];
  logic         vld      [2];
  logic [0:D-1] hv_out   [2];
`ifdef TEMPORAL_ENCODER_WINDOW_CNT_EN
  logic [15:0]  wcnt     [2];
`endif

  int errors = 0;
  int checks = 0;

  temporal_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(3), .WINDOW(3)) dut_a (
    .Clk_CI(clk), .Reset_RBI(rst_n), .ValidIn_SI(valid_in[0]), .ReadyOut_SO(rdy[0]),
    .HypervectorIn_DI(hv_in[0]), .ValidOut_SO(vld[0]), .ReadyIn_SI(ready_in[0]),
    .HypervectorOut_DO(hv_out[0])
`ifdef TEMPORAL_ENCODER_WINDOW_CNT_EN
    , .WindowCnt_DO(wcnt[0])
`endif
  );

  temporal_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(3), .WINDOW(2)) dut_b (
    .Clk_CI(clk), .Reset_RBI(rst_n), .ValidIn_SI(valid_in[1]), .ReadyOut_SO(rdy[1]),
    .HypervectorIn_DI(hv_in[1]), .ValidOut_SO(vld[1]), .ReadyIn_SI(ready_in[1]),
    .HypervectorOut_DO(hv_out[1])
`ifdef TEMPORAL_ENCODER_WINDOW_CNT_EN
    , .WindowCnt_DO(wcnt[1])
`endif
  );

  // rho: every bit moves one index up, the last index wraps to index 0.
  function automatic logic [0:D-1] rho1(input logic [0:D-1] x);
    return {x[D-1], x[0:D-2]};
  endfunction

  function automatic int win_of(input int k);
    return (k == 0) ? 3 : 2;
  endfunction

  // Model state: previous two samples, samples seen since reset, per-bit ones count.
  logic [0:D-1] mh     [2][2];
  int           mseen  [2];
  int           ones   [2][D];
  int           nng    [2];
  logic         mvalid [2];
  logic         mready [2];
  logic [0:D-1] mout   [2];
  int           mhs    [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mh[k][0] = '0; mh[k][1] = '0;
      mseen[k] = 0; nng[k] = 0;
      for (int i = 0; i < D; i++) ones[k][i] = 0;
      mvalid[k] = 1'b0; mready[k] = 1'b0; mout[k] = '0; mhs[k] = 0;
    end
  endtask

  initial begin
    logic [0:D-1] ng;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (mvalid[k]) begin
            if (ready_in[k]) begin
              mvalid[k] = 1'b0;
              mhs[k]++;
            end
          end else if (mready[k] && valid_in[k]) begin
            ng = hv_in[k] ^ rho1(mh[k][0]) ^ rho1(rho1(mh[k][1]));
            if (mseen[k] >= 2) begin
              for (int i = 0; i < D; i++) ones[k][i] += int'(ng[i]);
              nng[k]++;
              if (nng[k] == win_of(k)) begin
                for (int i = 0; i < D; i++) begin
                  mout[k][i] = (2 * ones[k][i] > win_of(k));
                  ones[k][i] = 0;
                end
                nng[k]    = 0;
                mvalid[k] = 1'b1;
              end
            end
            mseen[k]++;
            mh[k][1] = mh[k][0];
            mh[k][0] = hv_in[k];
          end
          mready[k] = !mvalid[k];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("ready[%0d]", k), 32'(rdy[k]), 32'(mready[k]));
        chk($sformatf("valid[%0d]", k), 32'(vld[k]), 32'(mvalid[k]));
        chk($sformatf("hv_out[%0d]", k), 32'(hv_out[k]), 32'(mout[k]));
`ifdef TEMPORAL_ENCODER_WINDOW_CNT_EN
        chk($sformatf("wcnt[%0d]", k), 32'(wcnt[k]), 32'(mhs[k]));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [0:D-1] x);
    int n;
    n = 0;
    valid_in[k] = 1'b1;
    hv_in[k]    = x;
    while (rdy[k] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout[%0d]: ready never rose within 50 cycles", k);
    end
    step();
  endtask

  // Picks the input that yields the requested n-gram given the model's history.
  task automatic send_ng(input int k, input logic [0:D-1] ng);
    send(k, ng ^ rho1(mh[k][0]) ^ rho1(rho1(mh[k][1])));
  endtask

  task automatic handshake(input int k);
    valid_in[k] = 1'b0;
    ready_in[k] = 1'b1;
    step();
    ready_in[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      valid_in[k] = 1'b0; ready_in[k] = 1'b0; hv_in[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(vld[0]), 32'd0);
    chk("reset_ready", 32'(rdy[0]), 32'd0);
    chk("reset_hv", 32'(hv_out[0]), 32'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", 32'(rdy[0]), 32'd1);

    // Two fill samples, then three constant samples complete the window.
    send(0, 8'b1000_0000);
    send(0, 8'b1000_0000);
    chk("no_valid_after_fill", 32'(vld[0]), 32'd0);
    chk("ready_in_accum", 32'(rdy[0]), 32'd1);
    for (int s = 0; s < 3; s++) send(0, 8'b1000_0000);
    chk("const_valid", 32'(vld[0]), 32'd1);
    chk("const_hv", 32'(hv_out[0]), 32'(8'b1110_0000));
    chk("const_ready_low", 32'(rdy[0]), 32'd0);

    // Downstream stalls while upstream keeps offering a sample.
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("hold_valid_%0d", c), 32'(vld[0]), 32'd1);
      chk($sformatf("hold_hv_%0d", c), 32'(hv_out[0]), 32'(8'b1110_0000));
    end
    handshake(0);
    chk("release_valid_low", 32'(vld[0]), 32'd0);
    chk("release_ready_high", 32'(rdy[0]), 32'd1);

    send_ng(0, 8'hF0);
    send_ng(0, 8'hF0);
    send_ng(0, 8'h0F);
    chk("mixed_valid", 32'(vld[0]), 32'd1);
    chk("mixed_hv", 32'(hv_out[0]), 32'(8'hF0));
    handshake(0);

    // Even window tie resolves to zero.
    send(1, 8'h11);
    send(1, 8'h22);
    send_ng(1, 8'hF0);
    send_ng(1, 8'h0F);
    chk("tie_valid", 32'(vld[1]), 32'd1);
    chk("tie_hv", 32'(hv_out[1]), 32'(8'h00));
    handshake(1);

    // Asynchronous reset after two n-grams of a window.
    send_ng(0, 8'hAA);
    send_ng(0, 8'h55);
    valid_in[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(vld[0]), 32'd0);
    chk("async_ready", 32'(rdy[0]), 32'd0);
    chk("async_hv", 32'(hv_out[0]), 32'd0);
    #10;
    rst_n = 1'b1;
    step();
    for (int s = 0; s < 4; s++) send(0, 8'b0011_1100);
    chk("post_reset_no_valid", 32'(vld[0]), 32'd0);
    send(0, 8'b0011_1100);
    chk("post_reset_valid", 32'(vld[0]), 32'd1);
    chk("post_reset_hv", 32'(hv_out[0]), 32'(8'h2D));
    handshake(0);

`ifdef TEMPORAL_ENCODER_WINDOW_CNT_EN
    for (int w = 0; w < 3; w++) begin
      for (int s = 0; s < 3; s++) send(0, 8'(8'h31 * (w + s + 1)));
      handshake(0);
    end
    chk("window_cnt_4", 32'(wcnt[0]), 32'd4);
`endif

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
